// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the PC / fetch-address stage.
//   state_t   : fetch FSM state encoding
//   RESET_PC  : PC loaded by reset
//   INC       : sequential fetch increment
//   JIDX_W    : width of the jump word index field
//   JALIGN_W  : word-alignment bits appended to a jump index
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0080;
  localparam logic [31:0] INC      = 32'd4;
  localparam int          JIDX_W   = 26;
  localparam int          JALIGN_W = 2;

endpackage

// File: rtl/pc_adder32.sv
// 32-bit ripple-carry adder.
//   z    : sum (a + b + cin), modulo 2^32
//   cout : carry out of bit 31
//   a, b : operands
//   cin  : carry in
module pc_adder32 (
  output logic [31:0] z,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin
);

  logic carry;

  always_comb begin
    z     = '0;
    carry = cin;
    for (int i = 0; i < 32; i++) begin
      z[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program-counter / fetch-address stage.
// Holds the PC, forms sequential, branch and jump targets, and offers the
// current PC downstream under a valid/ready handshake.
//   clk, rst   : clock, async active-high reset
//   start      : IDLE/HALT -> RUN pulse
//   halt_req   : RUN -> HALT request (wins over start)
//   branch,zero: taken branch when both high; imm is the word offset
//   jump       : jump to {pc_plus4[31:28], jtarget, 2'b00}
//   out_ready  : downstream accepts pc
//   out_valid  : pc is a valid fetch address (RUN only)
//   pc         : current fetch address
//   pc_plus4   : pc + INC, combinational
//   pc_wrap    : one-cycle pulse after a sequential advance carried out
//   busy       : high in RUN
//
// state | meaning
// IDLE  | after reset, waiting for start, no fetch offered
// RUN   | fetch address offered, pc advances or redirects
// HALT  | fetch stopped, pc frozen, start resumes at same pc
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_PC_VAL = RESET_PC,
  parameter logic [31:0] INC_VAL      = INC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              branch,
  input  logic              zero,
  input  logic [WIDTH-1:0]  imm,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jtarget,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  pc_plus4,
  output logic              pc_wrap,
  output logic              busy
);

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic             wrap_n;
  logic             inc_cout;
  logic [WIDTH-1:0] br_target;
  logic             br_cout;
  logic [WIDTH-1:0] jmp_target;

  pc_adder32 u_inc (
    .z    (pc_plus4),
    .cout (inc_cout),
    .a    (pc),
    .b    (INC_VAL),
    .cin  (1'b0)
  );

  // Word offset scaled to bytes; the top two offset bits fall off the end,
  // matching modulo-2^32 target arithmetic.
  pc_adder32 u_br (
    .z    (br_target),
    .cout (br_cout),
    .a    (pc_plus4),
    .b    ({imm[WIDTH-3:0], 2'b00}),
    .cin  (1'b0)
  );

  // Branch-target carry and the shifted-out offset bits carry no meaning.
  logic unused_bits;
  assign unused_bits = &{1'b0, br_cout, imm[WIDTH-1:WIDTH-2]};

  assign jmp_target = {pc_plus4[WIDTH-1:JIDX_W+JALIGN_W], jtarget, {JALIGN_W{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC_VAL;
      pc_wrap <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pc_wrap <= wrap_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    wrap_n    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // Redirects load regardless of out_ready, dropping the offered address.
        if (jump) begin
          pc_n = jmp_target;
        end else if (branch && zero) begin
          pc_n = br_target;
        end else if (out_ready) begin
          pc_n   = pc_plus4;
          wrap_n = inc_cout;
        end
        if (halt_req) state_n = HALT;
      end
      HALT: begin
        if (start) state_n = RUN;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter / fetch-address stage of the single-cycle datapath; it sits directly upstream of the instruction-memory read.
- Holds the current PC and computes PC+4 with the 32-bit ripple adder.
- Forms branch and jump targets and selects the next PC.
- Presents each fetch address downstream under a valid/ready handshake, with run, halt and stall control.

Parameters:
- WIDTH, 32, address/data width; only 32 is supported.
- RESET_PC, 32'h0000_0080, PC value loaded by reset.
- INC, 32'd4, sequential increment.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; IDLE->RUN.
- halt_req  in  1  RUN->HALT request.
- branch  in  1  conditional-branch instruction flag.
- zero  in  1  ALU zero flag; the branch is taken when branch&&zero.
- imm  in  32  sign-extended branch offset, in words.
- jump  in  1  jump instruction flag.
- jtarget  in  26  jump word index.
- out_ready  in  1  downstream accepts the fetch address.
- out_valid  out  1  fetch address valid.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc+INC, combinational from pc.
- pc_wrap  out  1  one-cycle pulse when a sequential advance carried out of bit 31.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE.
  - out_valid=0, pc_wrap=0, busy=0.
- States IDLE, RUN, HALT:
  - IDLE: out_valid=0. When start=1, go to RUN at the next edge with pc unchanged.
  - RUN: out_valid=1, busy=1.
  - HALT: out_valid=0, pc frozen, busy=0. When start=1, go to RUN with pc unchanged (resume).
- halt_req in RUN:
  - Takes effect at the next edge.
  - If a handshake (out_valid&&out_ready) occurs in that same cycle, the pc advance still happens, then the state moves to HALT.
  - halt_req outside RUN is ignored.
- Redirect in RUN only:
  - jump=1: next pc = {pc_plus4[31:28], jtarget, 2'b00}.
  - Else branch&&zero: next pc = pc_plus4 + (imm<<2). Carry is discarded; the second adder instance computes this.
  - A redirect loads pc at the next edge regardless of out_ready, which flushes the unaccepted address.
  - Priority: jump > taken branch > sequential.
- Sequential advance: in RUN with out_valid&&out_ready and no redirect, pc <= pc_plus4.
- Stall: in RUN with out_ready=0 and no redirect, pc holds and out_valid stays 1 (address stable).
- Wrap:
  - pc=32'hFFFF_FFFC advancing sequentially gives pc=0.
  - pc_wrap=1 for exactly the cycle after that edge.
  - No pc_wrap on redirect.
- Latency: one cycle from an accepted handshake or redirect to the new pc value.
- pc_plus4 is combinational from pc; it is valid in every state.
- start in RUN is ignored.
- start and halt_req together in RUN: halt wins.
- Reset asserted mid-RUN: all outputs return to reset values immediately; the bench sees out_valid fall without a clock edge.
- All arithmetic is modulo 2^32.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'b00, RUN=2'b01, HALT=2'b10.
  - RESET_PC, INC.
  - Jump-field widths: 26 index bits, 2 alignment bits.
- Sub-module pc_adder32, ports (z, cout, a, b, cin), 32-bit ripple:
  - one instance for pc+INC, whose cout drives pc_wrap;
  - one instance for the branch target.
- FSM, next-pc mux and pc register live in pc_fetch_stage.

Test Plan:
- Reset then start pulse, out_ready=1, 3 cycles -> pc 0x80, 0x84, 0x88, 0x8C; out_valid=1 from the cycle after start; pc_plus4 always pc+4.
- RUN at pc=0x100, out_ready=0 for 4 cycles -> pc stays 0x100 and out_valid=1; raise out_ready -> next pc 0x104.
- pc=0x200, branch=1, zero=1, imm=32'hFFFF_FFFE (-2) -> next pc 0x1FC. Same with zero=0 -> 0x204.
- pc=0x1000_0040, jump=1, jtarget=26'h000_0010, branch&&zero=1 together -> jump wins, pc=0x1000_0040; redirect occurs with out_ready=0.
- Force pc=0xFFFF_FFFC via jump/branch, then out_ready=1 -> pc=0x0000_0000 and pc_wrap=1 for one cycle; halt_req then start -> out_valid 0 in HALT and pc frozen, resume at the same pc.
- Assert rst mid-RUN between clock edges -> pc=0x80, out_valid=0, busy=0 immediately; no advance until a new start.
